// File: rtl/output_wr_arbiter_pkg.sv
// output_wr_arbiter_pkg: FSM encodings, AXI constants and a log2 helper for the write arbiter
package output_wr_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/output_wr_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first request after ptr (with wrap), one-hot grant plus index
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] j;
   always_comb begin
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int k = N; k >= 1; k--) begin
         j = IW'((int'(ptr) + k) % N);
         if (req[j]) begin
            idx = j;
            any = 1'b1;
         end
      end
      gnt = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/output_wr_arbiter.sv
// output_wr_arbiter: round-robin share of one AXI4 AW/W/B write channel among NUM_CH writers
module output_wr_arbiter
   import output_wr_arbiter_pkg::*;
#(
   parameter int NUM_CH             = 4,
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 64,
   parameter int AXI_ID             = 0
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_CH-1:0]                      ch_req,
   input  logic [NUM_CH*C_S_AXI_ADDR_WIDTH-1:0]   ch_addr,
   input  logic [NUM_CH*8-1:0]                    ch_len,
   output logic [NUM_CH-1:0]                      ch_gnt,
   input  logic [NUM_CH*C_S_AXI_DATA_WIDTH-1:0]   ch_wdata,
   input  logic [NUM_CH*C_S_AXI_DATA_WIDTH/8-1:0] ch_wstrb,
   input  logic [NUM_CH-1:0]                      ch_wvalid,
   output logic [NUM_CH-1:0]                      ch_wready,
   output logic [NUM_CH-1:0]                      ch_done,
   output logic [1:0]                             ch_bresp,
   output logic [C_S_AXI_ID_WIDTH-1:0]            M_axi_awid,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]          M_axi_awaddr,
   output logic [7:0]                             M_axi_awlen,
   output logic [2:0]                             M_axi_awsize,
   output logic [1:0]                             M_axi_awburst,
   output logic                                   M_axi_awvalid,
   input  logic                                   M_axi_awready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          M_axi_wdata,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]        M_axi_wstrb,
   output logic                                   M_axi_wlast,
   output logic                                   M_axi_wvalid,
   input  logic                                   M_axi_wready,
   input  logic [C_S_AXI_ID_WIDTH-1:0]            M_axi_bid,
   input  logic [1:0]                             M_axi_bresp,
   input  logic                                   M_axi_bvalid,
   output logic                                   M_axi_bready
);
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int IW = $clog2(NUM_CH);
   state_t            state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     owner;
   logic [IW-1:0]     pick_idx;
   logic [NUM_CH-1:0] pick_gnt;
   logic              pick_any;
   logic [7:0]        beat_cnt;
   logic              w_fire;
   logic              bid_unused;
   rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
      .req(ch_req),
      .ptr(ptr),
      .gnt(pick_gnt),
      .idx(pick_idx),
      .any(pick_any)
   );
   assign M_axi_awid    = C_S_AXI_ID_WIDTH'(AXI_ID);
   assign M_axi_awsize  = 3'(clog2(SW));
   assign M_axi_awburst = AXI_BURST_INCR;
   assign bid_unused    = ^M_axi_bid;
   always_comb begin
      M_axi_wvalid = (state == ST_DATA) && ch_wvalid[owner];
      M_axi_wdata  = ch_wdata[owner*DW +: DW];
      M_axi_wstrb  = ch_wstrb[owner*SW +: SW];
      M_axi_wlast  = (state == ST_DATA) && (beat_cnt == M_axi_awlen);
      ch_wready    = (state == ST_DATA) ? NUM_CH'(M_axi_wready) << owner : '0;
      w_fire       = M_axi_wvalid && M_axi_wready;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         ptr           <= IW'(NUM_CH - 1);
         owner         <= '0;
         beat_cnt      <= '0;
         M_axi_awaddr  <= '0;
         M_axi_awlen   <= '0;
         M_axi_awvalid <= 1'b0;
         M_axi_bready  <= 1'b0;
         ch_gnt        <= '0;
         ch_done       <= '0;
         ch_bresp      <= AXI_RESP_OKAY;
      end else begin
         ch_gnt  <= '0;
         ch_done <= '0;
         case (state)
            ST_IDLE: if (pick_any) begin
               ch_gnt        <= pick_gnt;
               owner         <= pick_idx;
               ptr           <= pick_idx;
               M_axi_awaddr  <= ch_addr[pick_idx*AW +: AW];
               M_axi_awlen   <= ch_len[pick_idx*8 +: 8];
               M_axi_awvalid <= 1'b1;
               state         <= ST_ADDR;
            end
            ST_ADDR: if (M_axi_awready) begin
               M_axi_awvalid <= 1'b0;
               beat_cnt      <= '0;
               state         <= ST_DATA;
            end
            ST_DATA: if (w_fire) begin
               beat_cnt <= beat_cnt + 8'd1;
               if (M_axi_wlast) begin
                  M_axi_bready <= 1'b1;
                  state        <= ST_RESP;
               end
            end
            ST_RESP: if (M_axi_bvalid) begin
               ch_done      <= NUM_CH'(1) << owner;
               ch_bresp     <= M_axi_bresp;
               M_axi_bready <= 1'b0;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_output_wr_arbiter.sv
// tb_output_wr_arbiter: random writers and slave against a transaction-level model of the arbiter
module tb_output_wr_arbiter;
   localparam int N = 4, AW = 32, DW = 64, SW = 8;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [N-1:0] ch_req = '0, ch_gnt, ch_wvalid = '0, ch_wready, ch_done;
   logic [N*AW-1:0] ch_addr = '0;
   logic [N*8-1:0] ch_len = '0;
   logic [N*DW-1:0] ch_wdata = '0;
   logic [N*SW-1:0] ch_wstrb = '0;
   logic [1:0] ch_bresp;
   logic [0:0] M_axi_awid, M_axi_bid = '0;
   logic [AW-1:0] M_axi_awaddr;
   logic [7:0] M_axi_awlen;
   logic [2:0] M_axi_awsize;
   logic [1:0] M_axi_awburst, M_axi_bresp = '0;
   logic M_axi_awvalid, M_axi_awready = 1'b0, M_axi_wlast, M_axi_wvalid, M_axi_wready = 1'b0;
   logic [DW-1:0] M_axi_wdata;
   logic [SW-1:0] M_axi_wstrb;
   logic M_axi_bvalid = 1'b0, M_axi_bready;
   always #5 clk = ~clk;
   output_wr_arbiter #(.NUM_CH(N)) dut (
      .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
      .ch_gnt(ch_gnt), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_wvalid(ch_wvalid),
      .ch_wready(ch_wready), .ch_done(ch_done), .ch_bresp(ch_bresp),
      .M_axi_awid(M_axi_awid), .M_axi_awaddr(M_axi_awaddr), .M_axi_awlen(M_axi_awlen),
      .M_axi_awsize(M_axi_awsize), .M_axi_awburst(M_axi_awburst), .M_axi_awvalid(M_axi_awvalid),
      .M_axi_awready(M_axi_awready), .M_axi_wdata(M_axi_wdata), .M_axi_wstrb(M_axi_wstrb),
      .M_axi_wlast(M_axi_wlast), .M_axi_wvalid(M_axi_wvalid), .M_axi_wready(M_axi_wready),
      .M_axi_bid(M_axi_bid), .M_axi_bresp(M_axi_bresp), .M_axi_bvalid(M_axi_bvalid),
      .M_axi_bready(M_axi_bready)
   );
   int total = 0, bad = 0;
   logic [N-1:0] busy = '0;
   int quota [N];
   int fix_len [N];
   logic [AW-1:0] fix_addr [N];
   logic hold = 1'b0, all_now = 1'b0, aw_block = 1'b0, force_en = 1'b0;
   logic [1:0] force_v = 2'b00;
   int wv_pct = 70, wr_pct = 70;
   int m_st = 0, m_ptr = N - 1, m_owner = 0, m_beats = 0, m_wlasts = 0, mw = 0;
   logic [AW-1:0] m_addr = '0;
   logic [7:0] m_len = '0;
   logic [N-1:0] e_gnt = '0, e_done = '0;
   logic [1:0] e_bresp = '0;
   int gnt_q[$];
   int done_cnt [N];
   int last_beats = 0, last_wlasts = 0, beat_total = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int winner(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_awvalid", M_axi_awvalid, 0);
         chk("rst_wvalid", M_axi_wvalid, 0);
         chk("rst_wlast", M_axi_wlast, 0);
         chk("rst_bready", M_axi_bready, 0);
         chk("rst_gnt", ch_gnt, 0);
         chk("rst_done", ch_done, 0);
         chk("rst_wready", ch_wready, 0);
         chk("rst_bresp", ch_bresp, 0);
         chk("rst_awaddr", M_axi_awaddr, 0);
         chk("rst_awlen", M_axi_awlen, 0);
         m_st = 0; m_ptr = N - 1; e_gnt = '0; e_done = '0; e_bresp = '0; m_beats = 0;
      end else begin
         chk("gnt", ch_gnt, e_gnt);
         chk("done", ch_done, e_done);
         chk("bresp", ch_bresp, e_bresp);
         chk("awvalid", M_axi_awvalid, m_st == 1);
         chk("bready", M_axi_bready, m_st == 3);
         chk("awsize", M_axi_awsize, 3);
         chk("awburst", M_axi_awburst, 1);
         chk("awid", M_axi_awid, 0);
         if (m_st == 1) begin
            chk("awaddr", M_axi_awaddr, m_addr);
            chk("awlen", M_axi_awlen, m_len);
         end
         if (m_st == 2) begin
            chk("wvalid", M_axi_wvalid, ch_wvalid[m_owner]);
            chk("wready", ch_wready, N'(M_axi_wready) << m_owner);
            if (ch_wvalid[m_owner]) begin
               chk("wdata", M_axi_wdata, ch_wdata[m_owner*DW +: DW]);
               chk("wstrb", M_axi_wstrb, ch_wstrb[m_owner*SW +: SW]);
               chk("wlast", M_axi_wlast, m_beats == int'(m_len));
            end
         end else begin
            chk("idle_wvalid", M_axi_wvalid, 0);
            chk("idle_wready", ch_wready, 0);
         end
         e_gnt = '0;
         e_done = '0;
         case (m_st)
            0: begin
               mw = winner(ch_req, m_ptr);
               if (mw >= 0) begin
                  e_gnt[mw] = 1'b1;
                  m_owner = mw;
                  m_ptr = mw;
                  m_addr = ch_addr[mw*AW +: AW];
                  m_len = ch_len[mw*8 +: 8];
                  gnt_q.push_back(mw);
                  m_st = 1;
               end
            end
            1: if (M_axi_awready) begin
               m_st = 2;
               m_beats = 0;
               m_wlasts = 0;
            end
            2: if (ch_wvalid[m_owner] && M_axi_wready) begin
               beat_total++;
               if (M_axi_wlast) m_wlasts++;
               if (m_beats == int'(m_len)) begin
                  m_st = 3;
                  last_beats = m_beats + 1;
                  last_wlasts = m_wlasts;
               end
               m_beats++;
            end
            default: if (M_axi_bvalid) begin
               e_done[m_owner] = 1'b1;
               e_bresp = M_axi_bresp;
               done_cnt[m_owner]++;
               m_st = 0;
            end
         endcase
      end
   end
   task automatic step();
      for (int i = 0; i < N; i++) begin
         if (ch_done[i]) busy[i] = 1'b0;
         if (ch_gnt[i]) begin
            busy[i] = 1'b1;
            if (!hold) ch_req[i] = 1'b0;
         end
         if (!busy[i] && !ch_req[i] && quota[i] > 0 && (all_now || $urandom_range(3) == 0)) begin
            ch_req[i] = 1'b1;
            quota[i]--;
            ch_len[i*8 +: 8] = fix_len[i] >= 0 ? 8'(fix_len[i]) : 8'($urandom_range(7));
            ch_addr[i*AW +: AW] = fix_len[i] >= 0 ? fix_addr[i] : ($urandom() & 32'hFFFF_FFF8);
         end
         ch_wvalid[i] = $urandom_range(99) < wv_pct;
         ch_wdata[i*DW +: DW] = {$urandom(), $urandom()};
         ch_wstrb[i*SW +: SW] = 8'($urandom());
      end
      M_axi_awready = !aw_block && $urandom_range(99) < 60;
      M_axi_wready = $urandom_range(99) < wr_pct;
      if (!M_axi_bready) M_axi_bvalid = 1'b0;
      else if (!M_axi_bvalid && $urandom_range(1) == 1) begin
         M_axi_bvalid = 1'b1;
         M_axi_bresp = force_en ? force_v : 2'($urandom_range(3));
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1 step();
      end
   endtask
   task automatic clear_bench();
      ch_req = '0; busy = '0; ch_wvalid = '0;
      M_axi_bvalid = 1'b0; M_axi_awready = 1'b0; M_axi_wready = 1'b0;
      for (int i = 0; i < N; i++) begin
         quota[i] = 0;
         fix_len[i] = -1;
      end
   endtask
   task automatic do_reset();
      @(posedge clk);
      #1 reset_n = 1'b0;
      clear_bench();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask
   function automatic bit idle_now();
      bit r;
      r = ch_req == '0 && busy == '0 && m_st == 0;
      for (int i = 0; i < N; i++) if (quota[i] > 0) r = 0;
      return r;
   endfunction
   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (!idle_now() && n < budget) begin
         tick();
         n++;
      end
      chk(name, idle_now(), 1);
   endtask
   task automatic wait_done(input string name, input int ch, input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt[ch] < target && n < budget) begin
         tick();
         n++;
      end
      chk(name, done_cnt[ch] >= target, 1);
   endtask
   initial begin
      int n, d, bt, sum0, sum1;
      for (int i = 0; i < N; i++) begin
         done_cnt[i] = 0;
         fix_addr[i] = '0;
      end
      clear_bench();
      do_reset();
      // single writer, 7-beat burst at 0x1000
      fix_len[0] = 6; fix_addr[0] = 32'h1000; quota[0] = 1;
      wait_done("t1_wait", 0, 1, 400);
      chk("t1_beats", last_beats, 7);
      chk("t1_wlasts", last_wlasts, 1);
      chk("t1_addr", m_addr, 32'h1000);
      chk("t1_len", m_len, 6);
      tick(5);
      chk("t1_done_once", done_cnt[0], 1);
      wait_idle("t1_idle", 200);
      // all four held together from reset pointer
      do_reset();
      gnt_q.delete();
      hold = 1'b1; all_now = 1'b1;
      for (int i = 0; i < N; i++) quota[i] = 1;
      n = 0;
      while (gnt_q.size() < 5 && n < 1000) begin
         tick();
         n++;
      end
      chk("t2_five_grants", gnt_q.size() >= 5, 1);
      if (gnt_q.size() >= 5) begin
         chk("t2_g0", gnt_q[0], 0);
         chk("t2_g1", gnt_q[1], 1);
         chk("t2_g2", gnt_q[2], 2);
         chk("t2_g3", gnt_q[3], 3);
         chk("t2_g4", gnt_q[4], 0);
      end
      hold = 1'b0; all_now = 1'b0;
      wait_idle("t2_idle", 1000);
      // random throttled traffic on all writers
      wv_pct = 60; wr_pct = 60;
      sum0 = 0;
      for (int i = 0; i < N; i++) sum0 += done_cnt[i];
      for (int i = 0; i < N; i++) quota[i] = 4;
      wait_idle("t3_idle", 6000);
      sum1 = 0;
      for (int i = 0; i < N; i++) sum1 += done_cnt[i];
      chk("t3_bursts", sum1 - sum0, 16);
      wv_pct = 70; wr_pct = 70;
      // AW stall for 20 cycles
      fix_len[1] = 3; fix_addr[1] = 32'h4440; aw_block = 1'b1; quota[1] = 1;
      n = 0;
      while (!M_axi_awvalid && n < 100) begin
         tick();
         n++;
      end
      chk("t4_awvalid_seen", M_axi_awvalid, 1);
      bt = beat_total;
      repeat (20) begin
         tick();
         chk("t4_awvalid_hold", M_axi_awvalid, 1);
         chk("t4_awaddr_hold", M_axi_awaddr, 32'h4440);
         chk("t4_awlen_hold", M_axi_awlen, 3);
         chk("t4_no_w", M_axi_wvalid, 0);
      end
      chk("t4_no_beats", beat_total - bt, 0);
      aw_block = 1'b0;
      wait_idle("t4_idle", 400);
      fix_len[1] = -1;
      // single-beat burst on ch 2 with SLVERR
      fix_len[2] = 0; fix_addr[2] = 32'h2000; force_en = 1'b1; force_v = 2'b10; quota[2] = 1;
      d = done_cnt[2];
      wait_done("t5_wait", 2, d + 1, 400);
      chk("t5_done", ch_done, 4'b0100);
      chk("t5_bresp", ch_bresp, 2'b10);
      chk("t5_beats", last_beats, 1);
      chk("t5_wlasts", last_wlasts, 1);
      force_en = 1'b0; fix_len[2] = -1;
      wait_idle("t5_idle", 200);
      // reset in the middle of a long burst
      fix_len[3] = 15; fix_addr[3] = 32'h8000; wr_pct = 30; quota[3] = 1;
      n = 0;
      while (!(m_st == 2 && m_beats >= 2) && n < 500) begin
         tick();
         n++;
      end
      chk("t6_mid_data", m_st == 2 && m_beats >= 2, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_awvalid", M_axi_awvalid, 0);
      chk("t6_wvalid", M_axi_wvalid, 0);
      chk("t6_wlast", M_axi_wlast, 0);
      chk("t6_bready", M_axi_bready, 0);
      chk("t6_wready", ch_wready, 0);
      clear_bench();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      wr_pct = 70;
      gnt_q.delete();
      all_now = 1'b1;
      for (int i = 0; i < N; i++) quota[i] = 1;
      n = 0;
      while (gnt_q.size() < 1 && n < 50) begin
         tick();
         n++;
      end
      all_now = 1'b0;
      chk("t6_grant_seen", gnt_q.size() >= 1, 1);
      if (gnt_q.size() >= 1) chk("t6_first_ch0", gnt_q[0], 0);
      wait_idle("t6_idle", 1000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
